leaf_gpu_ingress_buffer: RTL and testbench

//  GPU-side ingress stage for a group leaf router. Buffers GPU flits and their 6-bit destination

---
 rtl/leaf_gpu_ingress_buffer_pkg.sv | 24 ++
 rtl/leaf_gpu_ingress_buffer_if.sv | 39 +++
 rtl/leaf_gpu_ingress_buffer_fifo.sv | 71 +++++++
 rtl/leaf_gpu_ingress_buffer.sv | 139 +++++++++++++
 tb/tb_leaf_gpu_ingress_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_gpu_ingress_buffer_pkg.sv
// Shared types and helpers for the leaf router GPU ingress buffer.
package leaf_gpu_ingress_buffer_pkg;

    localparam int ADDR_W  = 6;
    localparam int GROUP_W = 4;
    localparam int LEAF_W  = 2;
    localparam int CTR_W   = 16;

    localparam logic [GROUP_W-1:0] GROUP_ID_LEAF = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] val, input logic en);
        if (en && (val != {CTR_W{1'b1}})) begin
            return val + CTR_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/leaf_gpu_ingress_buffer_if.sv
// GPU-side ingress and router-side egress handshake signals of the ingress buffer.
interface leaf_gpu_ingress_buffer_if #(
    parameter int DWIDTH = 16
);
    import leaf_gpu_ingress_buffer_pkg::*;

    logic [DWIDTH-1:0] gpu_in_data;
    logic              gpu_in_valid;
    logic [ADDR_W-1:0] gpu_dest_addr;
    logic              gpu_in_ready;

    logic [DWIDTH-1:0] rtr_data;
    logic [ADDR_W-1:0] rtr_dest_addr;
    logic              rtr_valid;
    logic              rtr_ready;

    modport master (
        output gpu_in_data,
        output gpu_in_valid,
        output gpu_dest_addr,
        input  gpu_in_ready,
        input  rtr_data,
        input  rtr_dest_addr,
        input  rtr_valid,
        output rtr_ready
    );

    modport slave (
        input  gpu_in_data,
        input  gpu_in_valid,
        input  gpu_dest_addr,
        output gpu_in_ready,
        output rtr_data,
        output rtr_dest_addr,
        output rtr_valid,
        input  rtr_ready
    );

endinterface

// File: rtl/leaf_gpu_ingress_buffer_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count only.
module leaf_gpu_ingress_buffer_fifo
    import leaf_gpu_ingress_buffer_pkg::*;
#(
    parameter  int WIDTH = 22,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/leaf_gpu_ingress_buffer.sv
// GPU ingress stage of a leaf router: self-address filter, flit FIFO, registered output stage,
// traffic/drop statistics and sticky stall watchdog.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | output register empty, rtr_valid=0, waiting for a flit
//  ST_SEND | output register holds a flit, rtr_valid=1, held until taken
module leaf_gpu_ingress_buffer
    import leaf_gpu_ingress_buffer_pkg::*;
#(
    parameter  int                 DWIDTH      = 16,
    parameter  int                 FIFO_DEPTH  = 8,
    parameter  logic [GROUP_W-1:0] GROUP_ID    = GROUP_ID_LEAF,
    parameter  logic [LEAF_W-1:0]  LEAF_IDX    = 2'd3,
    parameter  int                 STALL_LIMIT = 64,
    localparam int                 CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    leaf_gpu_ingress_buffer_if.slave  bus,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic [CNT_W-1:0]          fifo_count,
    output logic [CTR_W-1:0]          sent_count,
    output logic [CTR_W-1:0]          drop_count,
    output logic                      stall_timeout
);

    localparam int                ENT_W     = DWIDTH + ADDR_W;
    localparam int                STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [ADDR_W-1:0] SELF_ADDR = {GROUP_ID, LEAF_IDX};

    state_e              state_q, state_d;
    logic [DWIDTH-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CTR_W-1:0]    sent_q, sent_d;
    logic [CTR_W-1:0]    drop_q, drop_d;
    logic [STALL_W-1:0]  stall_left_q, stall_left_d;
    logic                timeout_q, timeout_d;

    logic                gpu_ready;
    logic                accept;
    logic                self_hit;
    logic                push;
    logic                pop;
    logic                handshake;
    logic [ENT_W-1:0]    fifo_rdata;

    leaf_gpu_ingress_buffer_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.gpu_in_data, bus.gpu_dest_addr}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Ready follows full only; a same-edge pop never opens a slot for the GPU.
    assign gpu_ready = !reset && !fifo_full;
    assign accept    = bus.gpu_in_valid && gpu_ready;
    assign self_hit  = (bus.gpu_dest_addr == SELF_ADDR);
    assign push      = accept && !self_hit;
    assign handshake = (state_q == ST_SEND) && bus.rtr_ready;

    assign bus.gpu_in_ready  = gpu_ready;
    assign bus.rtr_valid     = (state_q == ST_SEND);
    assign bus.rtr_data      = data_q;
    assign bus.rtr_dest_addr = addr_q;
    assign sent_count        = sent_q;
    assign drop_count        = drop_q;
    assign stall_timeout     = timeout_q;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        addr_d       = addr_q;
        pop          = 1'b0;
        stall_left_d = STALL_W'(STALL_LIMIT);
        timeout_d    = timeout_q;
        sent_d       = sat_inc(sent_q, handshake);
        drop_d       = sat_inc(drop_q, accept && self_hit);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop              = 1'b1;
                    {data_d, addr_d} = fifo_rdata;
                    state_d          = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.rtr_ready) begin
                    if (!fifo_empty) begin
                        pop              = 1'b1;
                        {data_d, addr_d} = fifo_rdata;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Down-counter holds at zero once the limit has been reached.
                    stall_left_d = (stall_left_q == '0) ? '0 : stall_left_q - STALL_W'(1);
                    if (stall_left_q <= STALL_W'(1)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            addr_q       <= '0;
            sent_q       <= '0;
            drop_q       <= '0;
            stall_left_q <= STALL_W'(STALL_LIMIT);
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            sent_q       <= sent_d;
            drop_q       <= drop_d;
            stall_left_q <= stall_left_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_leaf_gpu_ingress_buffer.sv
// Self-checking bench for the GPU ingress buffer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_leaf_gpu_ingress_buffer;
    import leaf_gpu_ingress_buffer_pkg::*;

    localparam int          DW    = 16;
    localparam int          DEPTH = 8;
    localparam int          LIMIT = 64;
    localparam logic [5:0]  SELF  = 6'b1000_11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_full, fifo_empty, stall_timeout;
    logic [3:0]  fifo_count;
    logic [15:0] sent_count, drop_count;

    always #5 clk = ~clk;

    leaf_gpu_ingress_buffer_if #(.DWIDTH(DW)) bus ();

    leaf_gpu_ingress_buffer #(
        .DWIDTH      (DW),
        .FIFO_DEPTH  (DEPTH),
        .GROUP_ID    (4'b1000),
        .LEAF_IDX    (2'd3),
        .STALL_LIMIT (LIMIT)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .sent_count    (sent_count),
        .drop_count    (drop_count),
        .stall_timeout (stall_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered flits in a queue plus one output slot.
    logic [21:0] m_q[$];
    logic        m_valid = 1'b0;
    logic [15:0] m_data  = '0;
    logic [5:0]  m_addr  = '0;
    int          m_sent  = 0;
    int          m_drop  = 0;
    int          m_run   = 0;
    logic        m_tout  = 1'b0;

    task automatic model_edge();
        bit acc;
        if (reset) begin
            m_q.delete();
            m_valid = 1'b0; m_data = '0; m_addr = '0;
            m_sent = 0; m_drop = 0; m_run = 0; m_tout = 1'b0;
        end else begin
            acc = bus.gpu_in_valid && (m_q.size() < DEPTH);
            if (m_valid && bus.rtr_ready && m_sent < 65535) m_sent++;
            if (m_valid && !bus.rtr_ready) begin
                m_run++;
                if (m_run >= LIMIT) m_tout = 1'b1;
            end else begin
                m_run = 0;
            end
            if (!m_valid || bus.rtr_ready) begin
                if (m_q.size() > 0) begin
                    {m_data, m_addr} = m_q.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (acc) begin
                if (bus.gpu_dest_addr == SELF) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_q.push_back({bus.gpu_in_data, bus.gpu_dest_addr});
                end
            end
        end
    endtask

    task automatic check_all();
        chk("rtr_valid",     bus.rtr_valid,     m_valid);
        chk("rtr_data",      bus.rtr_data,      m_data);
        chk("rtr_dest_addr", bus.rtr_dest_addr, m_addr);
        chk("fifo_count",    fifo_count,        m_q.size());
        chk("fifo_full",     fifo_full,         m_q.size() == DEPTH);
        chk("fifo_empty",    fifo_empty,        m_q.size() == 0);
        chk("sent_count",    sent_count,        m_sent);
        chk("drop_count",    drop_count,        m_drop);
        chk("stall_timeout", stall_timeout,     m_tout);
    endtask

    task automatic tick();
        #1;
        chk("gpu_in_ready", bus.gpu_in_ready, !reset && (m_q.size() < DEPTH));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [5:0] a, input logic r);
        bus.gpu_in_valid  = v;
        bus.gpu_in_data   = d;
        bus.gpu_dest_addr = a;
        bus.rtr_ready     = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic [5:0]  dest;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_data;
        logic [5:0]  e_addr;
        int          e_count;
        int          e_sent;
        int          e_drop;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [15:0] got[$];
        int          k;
        int          guard;
        bit          pre;
        int          mode;
        int          pct;

        drive(1'b0, '0, '0, 1'b1);

        // rst  vld  data      dest   rdy | valid data      addr   cnt sent drop
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, 16'h0000, 6'h00, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 16'hA5A5, 6'h04, 1'b1, 1'b0, 16'h0000, 6'h00, 1, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b1, 16'hA5A5, 6'h04, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, 16'hA5A5, 6'h04, 0, 1, 0};
        vecs[4]  = '{1'b0, 1'b1, 16'h1234, SELF,  1'b1, 1'b0, 16'hA5A5, 6'h04, 0, 1, 1};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, 16'hA5A5, 6'h04, 0, 1, 1};
        vecs[6]  = '{1'b0, 1'b1, 16'hBEEF, 6'h20, 1'b0, 1'b0, 16'hA5A5, 6'h04, 1, 1, 1};
        vecs[7]  = '{1'b0, 1'b1, 16'hCAFE, 6'h3F, 1'b0, 1'b1, 16'hBEEF, 6'h20, 1, 1, 1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 6'h00, 1'b0, 1'b1, 16'hBEEF, 6'h20, 1, 1, 1};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b1, 16'hCAFE, 6'h3F, 0, 2, 1};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, 16'hCAFE, 6'h3F, 0, 3, 1};

        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].vld, vecs[i].data, vecs[i].dest, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), bus.rtr_valid,     vecs[i].e_valid);
            chk($sformatf("vec%0d_data", i),  bus.rtr_data,      vecs[i].e_data);
            chk($sformatf("vec%0d_addr", i),  bus.rtr_dest_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_count", i), fifo_count,        vecs[i].e_count);
            chk($sformatf("vec%0d_sent", i),  sent_count,        vecs[i].e_sent);
            chk($sformatf("vec%0d_drop", i),  drop_count,        vecs[i].e_drop);
        end

        // Fill with the router stalled: 1 flit in the output stage + 8 in the FIFO.
        do_reset();
        k = 0;
        guard = 0;
        while (k < 9 && guard < 50) begin
            drive(1'b1, 16'h1000 + 16'(k), 6'h05, 1'b0);
            pre = (m_q.size() < DEPTH);
            tick();
            if (pre) k++;
            guard++;
        end
        chk("fill_accepted", k, 9);
        drive(1'b1, 16'h1FFF, 6'h05, 1'b0);
        tick();
        tick();
        chk("fill_full",  fifo_full,  1);
        chk("fill_count", fifo_count, 8);
        #1;
        chk("fill_ready", bus.gpu_in_ready, 0);
        drive(1'b0, '0, '0, 1'b1);
        guard = 0;
        while (guard < 20) begin
            #1;
            if (bus.rtr_valid && bus.rtr_ready) got.push_back(bus.rtr_data);
            tick();
            guard++;
        end
        chk("drain_total", got.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) chk($sformatf("drain_order%0d", i), got[i], 16'h1000 + 16'(i));
        end
        chk("drain_sent", sent_count, 9);

        // One flit held with the router stalled: watchdog at exactly LIMIT stalled edges.
        do_reset();
        drive(1'b1, 16'h7777, 6'h11, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        for (int i = 0; i < LIMIT - 1; i++) tick();
        chk("stall_before_limit", stall_timeout, 0);
        tick();
        chk("stall_at_limit", stall_timeout, 1);
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("stall_sticky", stall_timeout, 1);

        // Streaming: continuous push with the router always ready.
        do_reset();
        for (int i = 0; i < 101; i++) begin
            drive(1'b1, 16'($urandom), 6'($urandom_range(0, 31)), 1'b1);
            tick();
            if (i >= 1) chk("stream_valid", bus.rtr_valid, 1);
            chk("stream_count_le1", fifo_count <= 1, 1);
        end
        chk("stream_sent", sent_count, 99);

        // Reset while SEND is active with 5 flits buffered.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'h6000 + 16'(i), 6'h09, 1'b0);
            tick();
        end
        chk("midrst_pre_count", fifo_count, 5);
        chk("midrst_pre_valid", bus.rtr_valid, 1);
        reset = 1'b1;
        #1;
        chk("midrst_ready", bus.gpu_in_ready, 0);
        tick();
        chk("midrst_valid", bus.rtr_valid, 0);
        chk("midrst_empty", fifo_empty, 1);
        chk("midrst_sent",  sent_count, 0);
        chk("midrst_drop",  drop_count, 0);
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_stale", bus.rtr_valid, 0);
        end

        // Randomized traffic in phases of differing router back-pressure.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            mode = (c / 150) % 4;
            pct  = (mode == 0) ? 100 : (mode == 1) ? 50 : (mode == 2) ? 10 : 0;
            reset = ($urandom_range(0, 699) == 0);
            drive($urandom_range(0, 3) != 0,
                  16'($urandom),
                  ($urandom_range(0, 7) == 0) ? SELF : 6'($urandom),
                  $urandom_range(0, 99) < pct);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
